// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer_pkg
//  Description : Shared types and constants for the bit serializer and the
//                serial sequence detector benches that it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_serializer_pkg;

    // Serializer control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Level driven on the serial line while no word is being shifted
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Width of the bit index counter for a given word width
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : bit_serializer_pkg
`default_nettype wire

// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer_if
//  Description : Parallel load handshake plus serial output bundle of the
//                bit serializer. The slave side is the serializer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             x;
    logic             bit_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             done;
    logic             busy;

    // Word producer / serial consumer side
    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  x,
        input  bit_valid,
        input  bit_cnt,
        input  done,
        input  busy
    );

    // Serializer side
    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output x,
        output bit_valid,
        output bit_cnt,
        output done,
        output busy
    );

endinterface : bit_serializer_if
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Accepts parallel words over valid/ready and shifts them out
//                one bit per clock on x. A one-word holding buffer lets words
//                stream back to back with no idle cycle between them.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  wire              clk,
    input  wire              rst_n,
    bit_serializer_if.slave  bus
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;     // bits still to be shifted
    logic [WIDTH-1:0]   hold_q, hold_d;       // holding buffer word
    logic               hold_full_q, hold_full_d;
    logic               x_q, x_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_last;
    logic w_load_hold;   // held word moves into the shifter
    logic w_load_in;     // input word goes straight into the shifter
    logic w_to_hold;     // input word parks in the holding buffer
    logic w_advance;     // step to the next bit of the current word

    // Ready only depends on the hold flag, never on load_valid.
    assign w_accept    = bus.load_valid && !hold_full_q;
    assign w_last      = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
    assign w_load_hold = w_last && hold_full_q;
    assign w_load_in   = w_accept && ((state_q == IDLE) || (w_last && !hold_full_q));
    assign w_to_hold   = w_accept && (state_q == SHIFT) && !w_last;
    assign w_advance   = (state_q == SHIFT) && !w_last;

    // ------------------------------------------------------------------------
    // Bit-order dependent selection of the first bit and the remainder
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_load_word;
    logic             w_load_first;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_shift_first;
    logic [WIDTH-1:0] w_shift_rest;

    // A held word always has priority over the input at the end of a word.
    assign w_load_word = hold_full_q ? hold_q : bus.load_data;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_first  = w_load_word[WIDTH-1];
            assign w_load_rest   = w_load_word << 1;
            assign w_shift_first = shreg_q[WIDTH-1];
            assign w_shift_rest  = shreg_q << 1;
        end else begin : g_lsb_first
            assign w_load_first  = w_load_word[0];
            assign w_load_rest   = w_load_word >> 1;
            assign w_shift_first = shreg_q[0];
            assign w_shift_rest  = shreg_q >> 1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SHIFT only when nothing is queued behind the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !hold_full_q && !w_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registers only
    always_comb begin
        bus.load_ready = !hold_full_q;
        bus.x          = x_q;
        bus.bit_valid  = (state_q == SHIFT);
        bus.bit_cnt    = bit_cnt_q;
        bus.done       = w_last;
        bus.busy       = (state_q == SHIFT) || hold_full_q;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Next shifter / hold contents for load, advance, park and drain cases
    always_comb begin
        shreg_d     = shreg_q;
        x_d         = x_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (w_load_hold || w_load_in) begin
            shreg_d   = w_load_rest;
            x_d       = w_load_first;
            bit_cnt_d = '0;
        end else if (w_advance) begin
            shreg_d   = w_shift_rest;
            x_d       = w_shift_first;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (state_d == IDLE) begin
            x_d       = IDLE_BIT;
            bit_cnt_d = '0;
        end

        if (w_load_hold) begin
            hold_full_d = 1'b0;
        end
        if (w_to_hold) begin
            hold_d      = bus.load_data;
            hold_full_d = 1'b1;
        end
    end

    // Datapath registers; reset discards both the partial and the held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            x_q         <= IDLE_BIT;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            x_q         <= x_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule : bit_serializer
`default_nettype wire
